stack_arbiter: RTL and testbench

STACK_ARBITER -- requirements
Module: stack_arbiter

---
 rtl/stack_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 31 +++
 rtl/stack_arbiter.sv | 132 +++++++++++++
 tb/tb_stack_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared encodings for the stack arbiter: FSM states, stack op codes and
// requester identities.
package stack_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic OP_PUSH = 1'b1;
   localparam logic OP_POP  = 1'b0;

   localparam logic ID_A = 1'b0;
   localparam logic ID_B = 1'b1;

   localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. A lone request wins outright; on contention the
// pointer decides. The pointer moves to the other requester whenever a
// service completes.
module rr_arb2
   import stack_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req_a_i,
   input  logic req_b_i,
   input  logic upd_i,
   input  logic served_i,
   output logic gnt_id_o
);

   logic ptr_q;

   // Winner selection: pointer only matters when both requesters are asking.
   always_comb begin
      gnt_id_o = ID_A;
      if (req_a_i && req_b_i) gnt_id_o = ptr_q;
      else if (req_b_i)       gnt_id_o = ID_B;
   end

   // Pointer update: favour the requester that was not just served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     ptr_q <= ID_A;
      else if (upd_i) ptr_q <= ~served_i;
   end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates two requesters onto a single stack core. One operation is in
// flight at a time; full/empty rejections skip the strobe and ack a cycle
// earlier than a real stack access.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no operation; grant a winner and latch its op/data
// ST_ISSUE | strobe the core, or reject on full (push) / empty (pop)
// ST_WAIT  | core has acted; capture stk_dout for a pop
// ST_DONE  | ack the winner with its err flag, move the priority pointer
module stack_arbiter
   import stack_pkg::*;
#(
   parameter int DATA_WIDTH  = 4,
   parameter int STACK_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_a,
   input  logic                  req_b,
   input  logic                  op_a,
   input  logic                  op_b,
   input  logic [DATA_WIDTH-1:0] wdata_a,
   input  logic [DATA_WIDTH-1:0] wdata_b,
   output logic                  ack_a,
   output logic                  ack_b,
   output logic                  err_a,
   output logic                  err_b,
   output logic [DATA_WIDTH-1:0] rdata_a,
   output logic [DATA_WIDTH-1:0] rdata_b,
   output logic                  stk_push,
   output logic                  stk_pop,
   output logic [DATA_WIDTH-1:0] stk_din,
   input  logic [DATA_WIDTH-1:0] stk_dout,
   input  logic                  stk_full,
   input  logic                  stk_empty,
   output logic                  busy,
   output logic [ERR_CNT_W-1:0]  err_cnt
);

   // The core reports full/empty itself, so depth only needs to be sane.
   if (STACK_DEPTH < 1) begin : g_depth_chk
      $error("stack_arbiter: STACK_DEPTH must be at least 1");
   end

   state_e                state_q;
   logic                  win_q;
   logic                  op_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] rdata_a_q;
   logic [DATA_WIDTH-1:0] rdata_b_q;
   logic [ERR_CNT_W-1:0]  err_cnt_q;

   logic gnt_id;
   logic reject;

   rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_a_i  (req_a),
      .req_b_i  (req_b),
      .upd_i    (state_q == ST_DONE),
      .served_i (win_q),
      .gnt_id_o (gnt_id)
   );

   // Core-side strobes exist only in ST_ISSUE and only for an accepted op.
   always_comb begin
      reject   = (op_q == OP_PUSH) ? stk_full : stk_empty;
      stk_push = (state_q == ST_ISSUE) && (op_q == OP_PUSH) && !stk_full;
      stk_pop  = (state_q == ST_ISSUE) && (op_q == OP_POP)  && !stk_empty;
   end

   // Requester-side outputs decode from registered state.
   always_comb begin
      ack_a   = (state_q == ST_DONE) && (win_q == ID_A);
      ack_b   = (state_q == ST_DONE) && (win_q == ID_B);
      err_a   = ack_a && err_q;
      err_b   = ack_b && err_q;
      rdata_a = rdata_a_q;
      rdata_b = rdata_b_q;
      stk_din = wdata_q;
      busy    = (state_q != ST_IDLE);
      err_cnt = err_cnt_q;
   end

   // Sequencing FSM with its datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         win_q     <= ID_A;
         op_q      <= OP_POP;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         rdata_a_q <= '0;
         rdata_b_q <= '0;
         err_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_a || req_b) begin
                  win_q   <= gnt_id;
                  op_q    <= (gnt_id == ID_B) ? op_b : op_a;
                  wdata_q <= (gnt_id == ID_B) ? wdata_b : wdata_a;
                  err_q   <= 1'b0;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (reject) begin
                  err_q <= 1'b1;
                  if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (op_q == OP_POP) begin
                  if (win_q == ID_B) rdata_b_q <= stk_dout;
                  else               rdata_a_q <= stk_dout;
               end
               state_q <= ST_DONE;
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural 16-entry stack core.
// Inputs change and outputs are sampled on the falling edge; "cycle 0" is
// the cycle whose closing rising edge samples the request in IDLE.
module tb_stack_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_a, req_b, op_a, op_b;
   logic [3:0] wdata_a, wdata_b;
   logic       ack_a, ack_b, err_a, err_b;
   logic [3:0] rdata_a, rdata_b;
   logic       stk_push, stk_pop;
   logic [3:0] stk_din;
   logic [3:0] stk_dout = 4'h0;
   logic       stk_full, stk_empty;
   logic       busy;
   logic [7:0] err_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   logic [3:0] mem [16];
   int         sp = 0;

   always #5 clk = ~clk;

   stack_arbiter #(.DATA_WIDTH(4), .STACK_DEPTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
      .wdata_a(wdata_a), .wdata_b(wdata_b),
      .ack_a(ack_a), .ack_b(ack_b), .err_a(err_a), .err_b(err_b),
      .rdata_a(rdata_a), .rdata_b(rdata_b),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
      .stk_dout(stk_dout), .stk_full(stk_full), .stk_empty(stk_empty),
      .busy(busy), .err_cnt(err_cnt)
   );

   // Stack core model: dout is registered, valid the cycle after a pop.
   assign stk_full  = (sp == 16);
   assign stk_empty = (sp == 0);
   always @(posedge clk) begin
      if (stk_push && sp < 16) begin
         mem[sp] <= stk_din;
         sp      <= sp + 1;
      end else if (stk_pop && sp > 0) begin
         stk_dout <= mem[sp-1];
         sp       <= sp - 1;
      end
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input bit sb, input logic v, input logic op, input logic [3:0] d);
      if (sb) begin req_b = v; op_b = op; wdata_b = d; end
      else    begin req_a = v; op_a = op; wdata_a = d; end
   endtask

   // Accepted operation: strobe in cycle 1, ack in cycle 3.
   task automatic op_normal(input bit sb, input logic op, input logic [3:0] d,
                            input logic [3:0] exp_rd, input string tag);
      set_req(sb, 1'b1, op, d);
      @(negedge clk);
      chk({tag, ".c1_push"}, stk_push, op);
      chk({tag, ".c1_pop"},  stk_pop, !op);
      if (op) chk({tag, ".c1_din"}, stk_din, d);
      chk({tag, ".c1_busy"}, busy, 1'b1);
      @(negedge clk);
      chk({tag, ".c2_strobe"}, stk_push | stk_pop, 1'b0);
      chk({tag, ".c2_ack"}, sb ? ack_b : ack_a, 1'b0);
      @(negedge clk);
      chk({tag, ".c3_ack"}, sb ? ack_b : ack_a, 1'b1);
      chk({tag, ".c3_other_ack"}, sb ? ack_a : ack_b, 1'b0);
      chk({tag, ".c3_err"}, sb ? err_b : err_a, 1'b0);
      if (!op) chk({tag, ".c3_rdata"}, sb ? rdata_b : rdata_a, exp_rd);
      set_req(sb, 1'b0, 1'b0, 4'h0);
      @(negedge clk);
      chk({tag, ".c4_idle"}, busy, 1'b0);
   endtask

   // Rejected operation: no strobe, ack with err in cycle 2.
   task automatic op_reject(input bit sb, input logic op, input logic [3:0] d,
                            input logic [7:0] exp_cnt, input string tag);
      set_req(sb, 1'b1, op, d);
      @(negedge clk);
      chk({tag, ".c1_strobe"}, stk_push | stk_pop, 1'b0);
      @(negedge clk);
      chk({tag, ".c2_ack"}, sb ? ack_b : ack_a, 1'b1);
      chk({tag, ".c2_err"}, sb ? err_b : err_a, 1'b1);
      chk({tag, ".c2_errcnt"}, err_cnt, exp_cnt);
      set_req(sb, 1'b0, 1'b0, 4'h0);
      @(negedge clk);
      chk({tag, ".c3_idle"}, busy, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      req_a = 1'b0; req_b = 1'b0; op_a = 1'b0; op_b = 1'b0;
      wdata_a = 4'h0; wdata_b = 4'h0;
      @(negedge clk);
      @(negedge clk);
      chk("rst.busy", busy, 1'b0);
      chk("rst.ack", {ack_a, ack_b}, 2'b00);
      chk("rst.strobe", {stk_push, stk_pop}, 2'b00);
      chk("rst.errcnt", err_cnt, 8'd0);
      chk("rst.rdata", {rdata_a, rdata_b}, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // Pop on empty stack is rejected.
      op_reject(1'b0, 1'b0, 4'h0, 8'd1, "pop_empty");

      // Single push of 4'hA; a push does not disturb rdata_a.
      op_normal(1'b0, 1'b1, 4'hA, 4'h0, "push_a");
      chk("push_a.rdata_kept", rdata_a, 4'h0);

      // Round trip: A pushes 5, B pops it back; A then drains the 4'hA.
      op_normal(1'b0, 1'b1, 4'h5, 4'h0, "rt_push");
      op_normal(1'b1, 1'b0, 4'h0, 4'h5, "rt_pop_b");
      op_normal(1'b0, 1'b0, 4'h0, 4'hA, "pop_a");
      chk("pop_a.rdata_b_kept", rdata_b, 4'h5);

      // Reset clears the pointer and counters; contention then serves A, B.
      rst_n = 1'b0;
      #1;
      chk("rst2.errcnt", err_cnt, 8'd0);
      chk("rst2.rdata", {rdata_a, rdata_b}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      req_a = 1'b1; op_a = 1'b1; wdata_a = 4'h3;
      req_b = 1'b1; op_b = 1'b1; wdata_b = 4'h7;
      @(negedge clk);
      chk("cont1.din", stk_din, 4'h3);
      @(negedge clk);
      @(negedge clk);
      chk("cont1.ack", {ack_a, ack_b}, 2'b10);
      @(negedge clk);
      chk("cont1.idle", busy, 1'b0);
      @(negedge clk);
      chk("cont2.push", stk_push, 1'b1);
      chk("cont2.din", stk_din, 4'h7);
      @(negedge clk);
      @(negedge clk);
      chk("cont2.ack", {ack_a, ack_b}, 2'b01);
      req_a = 1'b0; req_b = 1'b0;
      @(negedge clk);

      // Pop of 7 by A, then B pops with its request dropped after grant.
      op_normal(1'b0, 1'b0, 4'h0, 4'h7, "pop7_a");
      req_b = 1'b1; op_b = 1'b0;
      @(negedge clk);
      req_b = 1'b0;
      chk("drop.pop", stk_pop, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("drop.ack", ack_b, 1'b1);
      chk("drop.rdata", rdata_b, 4'h3);
      @(negedge clk);
      chk("drop.no_regrant", busy, 1'b0);

      // Fill the stack, then a 17th push is rejected and the stack stays full.
      for (int i = 0; i < 16; i++) op_normal(1'b0, 1'b1, i[3:0], 4'h0, "fill");
      op_reject(1'b0, 1'b1, 4'hC, 8'd1, "push_full");
      chk("push_full.depth", sp[7:0], 8'd16);
      chk("push_full.full", stk_full, 1'b1);

      // Reset during WAIT abandons the pop without an ack.
      req_a = 1'b1; op_a = 1'b0;
      @(negedge clk);
      chk("rstw.pop", stk_pop, 1'b1);
      @(negedge clk);
      chk("rstw.busy_wait", busy, 1'b1);
      rst_n = 1'b0;
      req_a = 1'b0;
      #1;
      chk("rstw.busy", busy, 1'b0);
      chk("rstw.ack", ack_a, 1'b0);
      chk("rstw.errcnt", err_cnt, 8'd0);
      chk("rstw.rdata", rdata_a, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rstw.no_ack", {ack_a, ack_b}, 2'b00);
      end
      chk("rstw.depth", sp[7:0], 8'd15);
      op_normal(1'b0, 1'b0, 4'h0, 4'hE, "post_rst_pop");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
